// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event controller.
package btn_evt_pkg;

    localparam int unsigned N_BTN            = 5;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned HOLD_TICKS_DEF   = 1000;
    localparam int unsigned REPEAT_TICKS_DEF = 200;
    localparam int unsigned CNT_W_DEF        = 11;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } btn_state_e;

    // Round-robin successor of a button index.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_BTN - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/btn_repeat_fsm.sv
// Per-button press / hold-to-repeat FSM; emits a one-cycle raise strobe with its repeat flag.
module btn_repeat_fsm
    import btn_evt_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_raise,
    output logic o_raise_rpt
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    generate
        if (HOLD_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_ticks
            $error("btn_repeat_fsm: HOLD_TICKS and REPEAT_TICKS must be >= 2");
        end
        if ((HOLD_TICKS - 1) >= (64'd1 << CNT_W) || (REPEAT_TICKS - 1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
            $error("btn_repeat_fsm: CNT_W too narrow for tick constants");
        end
    endgenerate

    btn_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_raise     = 1'b0;
        o_raise_rpt = 1'b0;
        if (!i_btn) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    o_raise     = 1'b1;
                end
                HOLD: begin
                    // Saturates at HOLD_LAST so a later repeat_en rise fires immediately.
                    if (r_cnt == HOLD_LAST) begin
                        if (i_repeat_en) begin
                            w_state_nxt = REPEAT;
                            w_cnt_nxt   = '0;
                            o_raise     = 1'b1;
                            o_raise_rpt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (r_cnt == REPEAT_LAST) begin
                        w_cnt_nxt   = '0;
                        o_raise     = i_repeat_en;
                        o_raise_rpt = i_repeat_en;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: per-button repeat FSMs, pending bits and a round-robin
// arbiter feeding a single valid/ready event register.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             main_clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pin_debounce,
    input  logic             repeat_en,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_id,
    output logic             evt_repeat,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic [N_BTN-1:0] w_raise;
    logic [N_BTN-1:0] w_raise_rpt;
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_pend_rpt;
    logic [IDX_W-1:0] r_ptr;
    logic             r_evt_valid;
    logic [IDX_W-1:0] r_evt_id;
    logic             r_evt_repeat;
    logic             r_overrun;

    logic             w_free;
    logic             w_grant_vld;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_grant_rpt;
    logic [N_BTN-1:0] w_grant_oh;
    logic             w_ovr_set;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_repeat_fsm #(
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .i_clk      (main_clk),
            .i_rst      (rst),
            .i_btn      (btn_pin_debounce[g]),
            .i_repeat_en(repeat_en),
            .o_raise    (w_raise[g]),
            .o_raise_rpt(w_raise_rpt[g])
        );
    end

    assign w_free = !r_evt_valid || evt_ready;

    always_comb begin : arb
        int unsigned k;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_grant_rpt = 1'b0;
        w_grant_oh  = '0;
        k           = 0;
        if (w_free) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                k = (int'(r_ptr) + i) % N_BTN;
                if (!w_grant_vld && r_pend[k]) begin
                    w_grant_vld   = 1'b1;
                    w_grant_idx   = IDX_W'(k);
                    w_grant_rpt   = r_pend_rpt[k];
                    w_grant_oh[k] = 1'b1;
                end
            end
        end
    end

    assign w_ovr_set = |(w_raise & r_pend & ~w_grant_oh);

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_rpt <= '0;
        end else begin
            for (int unsigned b = 0; b < N_BTN; b++) begin
                // A raise on a slot being granted this cycle starts a fresh event.
                if (w_raise[b]) begin
                    r_pend[b]     <= 1'b1;
                    r_pend_rpt[b] <= (r_pend[b] && !w_grant_oh[b]) ? (r_pend_rpt[b] | w_raise_rpt[b])
                                                                   : w_raise_rpt[b];
                end else if (w_grant_oh[b]) begin
                    r_pend[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_evt_repeat <= 1'b0;
            r_ptr        <= '0;
        end else if (w_free) begin
            if (w_grant_vld) begin
                r_evt_valid  <= 1'b1;
                r_evt_id     <= w_grant_idx;
                r_evt_repeat <= w_grant_rpt;
                r_ptr        <= next_idx(w_grant_idx);
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_id     = r_evt_id;
    assign evt_repeat = r_evt_repeat;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl with short tick constants.
module tb_btn_event_ctrl;
    import btn_evt_pkg::*;

    typedef struct {
        logic [IDX_W-1:0] id;
        logic             rpt;
    } exp_t;

    logic             main_clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_pin_debounce;
    logic             repeat_en;
    logic             evt_ready;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_id;
    logic             evt_repeat;
    logic             overrun;
    logic             overrun_clr;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    btn_event_ctrl #(
        .HOLD_TICKS  (8),
        .REPEAT_TICKS(3),
        .CNT_W       (11)
    ) dut (
        .main_clk        (main_clk),
        .rst             (rst),
        .btn_pin_debounce(btn_pin_debounce),
        .repeat_en       (repeat_en),
        .evt_ready       (evt_ready),
        .evt_valid       (evt_valid),
        .evt_id          (evt_id),
        .evt_repeat      (evt_repeat),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
    );

    always #5 main_clk = ~main_clk;

    // Every handshake seen here consumes one expected event.
    always @(negedge main_clk) begin : monitor
        exp_t e;
        if (!rst && evt_valid && evt_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d rpt=%0d, want no event", evt_id, evt_repeat);
            end else begin
                e = sb_q.pop_front();
                if (evt_id !== e.id || evt_repeat !== e.rpt) begin
                    n_fail++;
                    $display("FAIL sb_event: got id=%0d rpt=%0d, want id=%0d rpt=%0d",
                             evt_id, evt_repeat, e.id, e.rpt);
                end
            end
        end
    end

    task automatic push(input int id, input logic rpt);
        exp_t e;
        e.id  = IDX_W'(id);
        e.rpt = rpt;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge main_clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s: got %0d events outstanding, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_pin_debounce = '0; repeat_en = 1'b1; evt_ready = 1'b1; overrun_clr = 1'b0;
        @(negedge main_clk);
        n_checks++;
        if ({evt_valid, evt_id, evt_repeat, overrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b id=%0d rpt=%b ovr=%b, want all 0",
                     evt_valid, evt_id, evt_repeat, overrun);
        end
        @(posedge main_clk); #1;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_press;
        push(2, 1'b0);
        btn_pin_debounce = 5'b00100;
        @(negedge main_clk);
        @(negedge main_clk);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL t1_early: got valid=%b, want 0 one edge after rise", evt_valid);
        end
        @(negedge main_clk);
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 3'd2) begin
            n_fail++; $display("FAIL t1_latency: got valid=%b id=%0d, want 1/2", evt_valid, evt_id);
        end
        @(posedge main_clk);
        @(posedge main_clk); #1;
        btn_pin_debounce = '0;
        tick(15);
        check_drained("t1_drain");
    endtask

    task automatic test_hold_repeat;
        push(0, 1'b0);
        for (int i = 0; i < 4; i++) push(0, 1'b1);
        btn_pin_debounce = 5'b00001;
        repeat (20) @(posedge main_clk);
        #1;
        btn_pin_debounce = '0;
        tick(20);
        check_drained("t2_drain");
    endtask

    task automatic test_back_to_back;
        push(1, 1'b0); push(3, 1'b0); push(4, 1'b0);
        btn_pin_debounce = 5'b11010;
        @(negedge main_clk);
        @(negedge main_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge main_clk);
            n_checks++;
            if (evt_valid !== 1'b1) begin
                n_fail++; $display("FAIL t3_b2b: got valid=%b at slot %0d, want 1", evt_valid, i);
            end
        end
        @(posedge main_clk); #1;
        btn_pin_debounce = '0;
        tick(10);
        check_drained("t3_drain_a");
        push(0, 1'b0); push(4, 1'b0);
        btn_pin_debounce = 5'b10001;
        tick(3);
        btn_pin_debounce = '0;
        tick(10);
        check_drained("t3_drain_b");
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL t3_no_overrun: got %b, want 0", overrun);
        end
    endtask

    task automatic test_overrun;
        evt_ready = 1'b0;
        push(1, 1'b0); push(1, 1'b0);
        btn_pin_debounce = 5'b00010; tick(1);
        btn_pin_debounce = '0;       tick(1);
        btn_pin_debounce = 5'b00010; tick(1);
        btn_pin_debounce = '0;       tick(1);
        btn_pin_debounce = 5'b00010; tick(1);
        btn_pin_debounce = '0;
        @(negedge main_clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++; $display("FAIL t4_overrun_set: got %b, want 1", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge main_clk);
            n_checks++;
            if (evt_valid !== 1'b1 || evt_id !== 3'd1 || evt_repeat !== 1'b0) begin
                n_fail++;
                $display("FAIL t4_hold_stable: got valid=%b id=%0d rpt=%b, want 1/1/0",
                         evt_valid, evt_id, evt_repeat);
            end
        end
        @(posedge main_clk); #1;
        evt_ready = 1'b1;
        tick(6);
        check_drained("t4_drain");
        overrun_clr = 1'b1; tick(1);
        overrun_clr = 1'b0;
        @(negedge main_clk);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL t4_overrun_clr: got %b, want 0", overrun);
        end
    endtask

    task automatic test_repeat_enable;
        repeat_en = 1'b0;
        push(3, 1'b0);
        btn_pin_debounce = 5'b01000;
        repeat (30) @(posedge main_clk);
        #1;
        repeat_en = 1'b1;
        for (int i = 0; i < 3; i++) push(3, 1'b1);
        @(negedge main_clk);
        @(negedge main_clk);
        @(negedge main_clk);
        n_checks++;
        if (evt_valid !== 1'b1 || evt_repeat !== 1'b1) begin
            n_fail++; $display("FAIL t5_en_repeat: got valid=%b rpt=%b, want 1/1", evt_valid, evt_repeat);
        end
        repeat (5) @(posedge main_clk);
        #1;
        btn_pin_debounce = '0;
        tick(10);
        check_drained("t5_drain");
    endtask

    task automatic test_reset_midrun;
        push(3, 1'b0);
        btn_pin_debounce = 5'b01000;
        repeat (10) @(posedge main_clk);
        #1;
        n_checks++;
        if (evt_valid !== 1'b1 || evt_repeat !== 1'b1) begin
            n_fail++; $display("FAIL t6_pre_rst: got valid=%b rpt=%b, want 1/1", evt_valid, evt_repeat);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({evt_valid, evt_id, evt_repeat, overrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL t6_rst_async: got valid=%b id=%0d rpt=%b ovr=%b, want all 0",
                     evt_valid, evt_id, evt_repeat, overrun);
        end
        repeat (3) @(posedge main_clk);
        #1;
        check_drained("t6_pre_release");
        push(3, 1'b0);
        rst = 1'b0;
        @(negedge main_clk);
        @(negedge main_clk);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL t6_first_edge: got valid=%b, want 0", evt_valid);
        end
        @(negedge main_clk);
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 3'd3 || evt_repeat !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_second_edge: got valid=%b id=%0d rpt=%b, want 1/3/0",
                     evt_valid, evt_id, evt_repeat);
        end
        @(posedge main_clk); #1;
        btn_pin_debounce = '0;
        tick(10);
        check_drained("t6_drain");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_back_to_back();
        test_overrun();
        test_repeat_enable();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
